// File: rtl/peridot_board_i2c_slave.sv
// Purpose : bit-level I2C slave PHY: pin sync/filter, START/STOP detect, MSB-first byte shift, 9th-clock ACK.
// Latency : pin change -> action after 2 sync clk + FILTER_LENGTH filter clk + 1 edge clk.
// Backpressure: ackwaitrequest holds SCL low at the ACK phase (when stretching is enabled).
// Ports   : clk/reset (sync, active-high); i2c_scl_i/o, i2c_sda_i/o open-drain pins (o: 0 = pull low);
//           condi_start/condi_stop/done_byte/done_ack 1-clk pulses; ackwaitrequest stretch request;
//           send_bytedata/send_bytedatavalid tx byte; recieve_bytedata rx byte; send_ackdata ACK to drive;
//           recieve_ackdata ACK seen from master.
module peridot_board_i2c_slave #(
    parameter int FILTER_LENGTH   = 3,
    parameter     STRETCH_FEATURE = "ENABLE"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i2c_scl_i,
    output logic       i2c_scl_o,
    input  logic       i2c_sda_i,
    output logic       i2c_sda_o,
    output logic       condi_start,
    output logic       condi_stop,
    output logic       done_byte,
    input  logic       ackwaitrequest,
    output logic       done_ack,
    input  logic [7:0] send_bytedata,
    input  logic       send_bytedatavalid,
    output logic [7:0] recieve_bytedata,
    input  logic       send_ackdata,
    output logic       recieve_ackdata
);

    localparam logic [2:0] LP_FILT_MAX  = 3'(FILTER_LENGTH - 1);
    localparam bit         LP_STRETCH_EN = (STRETCH_FEATURE == "ENABLE");

    typedef enum logic [1:0] {ST_IDLE, ST_BIT, ST_STRETCH, ST_ACK} state_t;

    // ---------------- input synchroniser and glitch filter ----------------
    logic [1:0] r_scl_sync, r_sda_sync;
    logic [2:0] r_scl_cnt, r_sda_cnt;
    logic       r_scl_f, r_sda_f, r_scl_fp, r_sda_fp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_cnt  <= '0;
            r_sda_cnt  <= '0;
            r_scl_f    <= 1'b1;
            r_sda_f    <= 1'b1;
            r_scl_fp   <= 1'b1;
            r_sda_fp   <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i2c_scl_i};
            r_sda_sync <= {r_sda_sync[0], i2c_sda_i};
            r_scl_fp   <= r_scl_f;
            r_sda_fp   <= r_sda_f;
            // Filtered level flips only after FILTER_LENGTH consecutive differing samples.
            if (r_scl_sync[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == LP_FILT_MAX) begin
                r_scl_f   <= r_scl_sync[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 3'd1;
            end
            if (r_sda_sync[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == LP_FILT_MAX) begin
                r_sda_f   <= r_sda_sync[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 3'd1;
            end
        end
    end

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_stretch;
    assign w_scl_rise = r_scl_f & ~r_scl_fp;
    assign w_scl_fall = ~r_scl_f & r_scl_fp;
    // SCL must be high now and last cycle, so an SDA change on an SCL edge is data.
    assign w_start    = ~r_sda_f & r_sda_fp & r_scl_f & r_scl_fp;
    assign w_stop     = r_sda_f & ~r_sda_fp & r_scl_f & r_scl_fp;
    assign w_stretch  = LP_STRETCH_EN & ackwaitrequest;

    // ---------------- FSM ----------------
    state_t     r_state, w_state_nxt;
    logic [3:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] r_rxbyte, w_rxbyte_nxt;
    logic       r_tx, w_tx_nxt;
    logic       r_scl_o, w_scl_o_nxt;
    logic       r_sda_o, w_sda_o_nxt;
    logic       r_ackrx, w_ackrx_nxt;
    logic       r_start_p, w_start_p;
    logic       r_stop_p, w_stop_p;
    logic       r_done_byte, w_done_byte;
    logic       r_done_ack, w_done_ack;

    // State and datapath register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_rxbyte    <= '0;
            r_tx        <= 1'b0;
            r_scl_o     <= 1'b1;
            r_sda_o     <= 1'b1;
            r_ackrx     <= 1'b0;
            r_start_p   <= 1'b0;
            r_stop_p    <= 1'b0;
            r_done_byte <= 1'b0;
            r_done_ack  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_shift     <= w_shift_nxt;
            r_rxbyte    <= w_rxbyte_nxt;
            r_tx        <= w_tx_nxt;
            r_scl_o     <= w_scl_o_nxt;
            r_sda_o     <= w_sda_o_nxt;
            r_ackrx     <= w_ackrx_nxt;
            r_start_p   <= w_start_p;
            r_stop_p    <= w_stop_p;
            r_done_byte <= w_done_byte;
            r_done_ack  <= w_done_ack;
        end
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = ST_BIT;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    w_state_nxt = ST_IDLE;
                ST_BIT:     if (w_scl_fall && r_bitcnt == 4'd8) w_state_nxt = ST_STRETCH;
                ST_STRETCH: if (!w_stretch) w_state_nxt = ST_ACK;
                ST_ACK:     if (w_scl_fall) w_state_nxt = ST_BIT;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs and datapath. bitcnt counts SCL rises, so the SCL fall that follows
    // START (bitcnt=0) is ignored and the fall with bitcnt=8 closes the byte.
    always_comb begin
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_rxbyte_nxt = r_rxbyte;
        w_tx_nxt     = r_tx;
        w_scl_o_nxt  = r_scl_o;
        w_sda_o_nxt  = r_sda_o;
        w_ackrx_nxt  = r_ackrx;
        w_start_p    = 1'b0;
        w_stop_p     = 1'b0;
        w_done_byte  = 1'b0;
        w_done_ack   = 1'b0;
        if (w_start) begin
            w_start_p    = 1'b1;
            w_scl_o_nxt  = 1'b1;
            w_sda_o_nxt  = 1'b1;
            w_tx_nxt     = 1'b0;
            w_bitcnt_nxt = '0;
            w_ackrx_nxt  = 1'b0;
        end else if (w_stop) begin
            w_stop_p    = 1'b1;
            w_scl_o_nxt = 1'b1;
            w_sda_o_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_BIT: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        if (!r_tx) w_shift_nxt = {r_shift[6:0], r_sda_f};
                    end
                    if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_done_byte = 1'b1;
                            w_sda_o_nxt = 1'b1;
                            if (!r_tx) w_rxbyte_nxt = r_shift;
                        end else if (r_tx && r_bitcnt != 4'd0) begin
                            // r_shift[7] is already on the line; present the next bit.
                            w_sda_o_nxt = r_shift[6];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                ST_STRETCH: begin
                    if (w_stretch) begin
                        w_scl_o_nxt = 1'b0;
                        if (r_tx) w_sda_o_nxt = 1'b1;
                    end else begin
                        w_scl_o_nxt = 1'b1;
                        w_sda_o_nxt = r_tx ? 1'b1 : ~send_ackdata;
                    end
                end
                ST_ACK: begin
                    if (w_scl_rise) w_ackrx_nxt = ~r_sda_f;
                    if (w_scl_fall) begin
                        w_done_ack   = 1'b1;
                        w_bitcnt_nxt = '0;
                        if (send_bytedatavalid) begin
                            w_tx_nxt    = 1'b1;
                            w_shift_nxt = send_bytedata;
                            w_sda_o_nxt = send_bytedata[7];
                        end else begin
                            w_tx_nxt    = 1'b0;
                            w_sda_o_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_scl_o_nxt = 1'b1;
                    w_sda_o_nxt = 1'b1;
                end
            endcase
        end
    end

    assign i2c_scl_o        = r_scl_o;
    assign i2c_sda_o        = r_sda_o;
    assign condi_start      = r_start_p;
    assign condi_stop       = r_stop_p;
    assign done_byte        = r_done_byte;
    assign done_ack         = r_done_ack;
    assign recieve_bytedata = r_rxbyte;
    assign recieve_ackdata  = r_ackrx;

endmodule

// File: tb/tb_peridot_board_i2c_slave.sv
module tb_peridot_board_i2c_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       i2c_scl_o, i2c_sda_o;
    logic       scl_pin, sda_pin;
    logic       condi_start, condi_stop, done_byte, done_ack;
    logic       ackwaitrequest = 1'b0;
    logic [7:0] send_bytedata = 8'h00;
    logic       send_bytedatavalid = 1'b0;
    logic [7:0] recieve_bytedata;
    logic       send_ackdata = 1'b1;
    logic       recieve_ackdata;

    int checks = 0;
    int failures = 0;
    int n_start = 0, n_stop = 0, n_byte = 0, n_ack = 0, n_stop_bad = 0, n_tmo = 0;

    always #5 clk = ~clk;

    // Open-drain wiring: master and slave both pull down.
    assign scl_pin = m_scl & i2c_scl_o;
    assign sda_pin = m_sda & i2c_sda_o;

    peridot_board_i2c_slave #(.FILTER_LENGTH(3), .STRETCH_FEATURE("ENABLE")) dut (
        .clk(clk), .reset(reset),
        .i2c_scl_i(scl_pin), .i2c_scl_o(i2c_scl_o),
        .i2c_sda_i(sda_pin), .i2c_sda_o(i2c_sda_o),
        .condi_start(condi_start), .condi_stop(condi_stop),
        .done_byte(done_byte), .ackwaitrequest(ackwaitrequest), .done_ack(done_ack),
        .send_bytedata(send_bytedata), .send_bytedatavalid(send_bytedatavalid),
        .recieve_bytedata(recieve_bytedata), .send_ackdata(send_ackdata),
        .recieve_ackdata(recieve_ackdata)
    );

    // Pulse counters
    always @(negedge clk) begin
        if (condi_start) n_start++;
        if (condi_stop) begin
            n_stop++;
            if (i2c_sda_o !== 1'b1 || i2c_scl_o !== 1'b1) n_stop_bad++;
        end
        if (done_byte) n_byte++;
        if (done_ack) n_ack++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_scl_high();
        int t = 0;
        while (scl_pin !== 1'b1 && t < 400) begin
            tick(1);
            t++;
        end
        if (t >= 400) n_tmo++;
    endtask

    // One SCL clock: SDA set mid-low, 16-clk high phase, 8-clk low tail.
    task automatic m_bit(input logic b, input int glitch, output logic drv, output logic drv_const);
        logic first;
        m_sda = b;
        tick(8);
        m_scl = 1'b1;
        wait_scl_high();
        first = i2c_sda_o;
        drv_const = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (glitch != 0 && i == 6) begin
                m_scl = 1'b0;
                tick(glitch);
                m_scl = 1'b1;
            end
            tick(1);
            if (i2c_sda_o !== first) drv_const = 1'b0;
        end
        drv = i2c_sda_o;
        m_scl = 1'b0;
        tick(8);
    endtask

    task automatic m_start();
        m_sda = 1'b1;
        tick(8);
        m_scl = 1'b1;
        wait_scl_high();
        tick(16);
        m_sda = 1'b0;
        tick(16);
        m_scl = 1'b0;
        tick(8);
    endtask

    task automatic m_stop();
        m_sda = 1'b0;
        tick(8);
        m_scl = 1'b1;
        wait_scl_high();
        tick(16);
        m_sda = 1'b1;
        tick(16);
    endtask

    task automatic m_write(input logic [7:0] d, input int glitch, output logic ack_drv, output logic ack_const);
        logic dv, dc;
        for (int i = 7; i >= 0; i--) m_bit(d[i], glitch, dv, dc);
        m_bit(1'b1, 0, ack_drv, ack_const);
    endtask

    task automatic m_read(input logic next_valid, input logic master_ack,
                          output logic [7:0] bits, output logic all_const);
        logic dv, dc;
        all_const = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, 0, dv, dc);
            bits[i] = dv;
            all_const = all_const & dc;
        end
        send_bytedatavalid = next_valid;
        m_bit(~master_ack, 0, dv, dc);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(5);
        checks++; if (i2c_scl_o !== 1'b1) begin failures++; $display("FAIL reset_scl got=%b exp=1", i2c_scl_o); end
        checks++; if (i2c_sda_o !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", i2c_sda_o); end
        checks++; if (recieve_bytedata !== 8'h00) begin failures++; $display("FAIL reset_rxbyte got=%h exp=00", recieve_bytedata); end
        checks++; if (recieve_ackdata !== 1'b0) begin failures++; $display("FAIL reset_ackrx got=%b exp=0", recieve_ackdata); end
        checks++;
        if ({condi_start, condi_stop, done_byte, done_ack} !== 4'b0000) begin
            failures++; $display("FAIL reset_pulses got=%b exp=0000", {condi_start, condi_stop, done_byte, done_ack});
        end
        reset = 1'b0;
        tick(10);
    endtask

    task automatic test_write_ack();
        int s0, b0, a0, t0;
        logic ad, ac;
        t0 = n_tmo; s0 = n_start; b0 = n_byte; a0 = n_ack;
        send_ackdata = 1'b1; send_bytedatavalid = 1'b0;
        m_start();
        checks++; if (n_start - s0 !== 1) begin failures++; $display("FAIL t1_start_pulse got=%0d exp=1", n_start - s0); end
        m_write(8'hA0, 0, ad, ac);
        checks++; if (n_byte - b0 !== 1) begin failures++; $display("FAIL t1_done_byte got=%0d exp=1", n_byte - b0); end
        checks++; if (recieve_bytedata !== 8'hA0) begin failures++; $display("FAIL t1_rx_byte got=%h exp=a0", recieve_bytedata); end
        checks++; if ({ad, ac} !== 2'b01) begin failures++; $display("FAIL t1_ack_drive got=%b const=%b exp=0 const=1", ad, ac); end
        checks++; if (recieve_ackdata !== 1'b1) begin failures++; $display("FAIL t1_ackrx got=%b exp=1", recieve_ackdata); end
        checks++; if (n_ack - a0 !== 1) begin failures++; $display("FAIL t1_done_ack got=%0d exp=1", n_ack - a0); end
        m_stop();
        checks++; if (n_tmo !== t0) begin failures++; $display("FAIL t1_timeout got=%0d exp=%0d", n_tmo, t0); end
    endtask

    task automatic test_tx();
        int a0, t0, bad;
        logic ad, ac, c;
        logic [7:0] bits;
        t0 = n_tmo;
        send_bytedata = 8'h4E; send_bytedatavalid = 1'b1;
        m_start();
        a0 = n_ack;
        m_write(8'hA1, 0, ad, ac);
        send_bytedata = 8'hB5;
        m_read(1'b1, 1'b1, bits, c);
        checks++; if (bits !== 8'h4E) begin failures++; $display("FAIL t2_tx_bits got=%h exp=4e", bits); end
        checks++; if (c !== 1'b1) begin failures++; $display("FAIL t2_tx_stable got=%b exp=1", c); end
        checks++; if (recieve_ackdata !== 1'b1) begin failures++; $display("FAIL t2_master_ack got=%b exp=1", recieve_ackdata); end
        m_read(1'b0, 1'b0, bits, c);
        checks++; if (bits !== 8'hB5) begin failures++; $display("FAIL t2_tx_bits2 got=%h exp=b5", bits); end
        checks++; if (recieve_ackdata !== 1'b0) begin failures++; $display("FAIL t2_master_nack got=%b exp=0", recieve_ackdata); end
        checks++; if (n_ack - a0 !== 3) begin failures++; $display("FAIL t2_done_ack got=%0d exp=3", n_ack - a0); end
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (i2c_sda_o !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL t2_sda_released got=%0d low clk exp=0", bad); end
        m_stop();
        checks++; if (n_tmo !== t0) begin failures++; $display("FAIL t2_timeout got=%0d exp=%0d", n_tmo, t0); end
    endtask

    task automatic test_stretch();
        int a0, b0, t0, nlow;
        logic dv, dc;
        logic [7:0] d;
        t0 = n_tmo; d = 8'h3C;
        send_bytedatavalid = 1'b0; ackwaitrequest = 1'b1;
        m_start();
        b0 = n_byte; a0 = n_ack;
        for (int i = 7; i >= 0; i--) m_bit(d[i], 0, dv, dc);
        nlow = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (i2c_scl_o === 1'b0) nlow++;
        end
        checks++; if (nlow !== 40) begin failures++; $display("FAIL t3_scl_held got=%0d clk exp=40", nlow); end
        checks++; if (n_ack - a0 !== 0) begin failures++; $display("FAIL t3_early_ack got=%0d exp=0", n_ack - a0); end
        ackwaitrequest = 1'b0;
        tick(1);
        checks++; if (i2c_scl_o !== 1'b1) begin failures++; $display("FAIL t3_scl_release got=%b exp=1", i2c_scl_o); end
        checks++; if (i2c_sda_o !== 1'b0) begin failures++; $display("FAIL t3_ack_after got=%b exp=0", i2c_sda_o); end
        m_bit(1'b1, 0, dv, dc);
        checks++; if ({dv, dc} !== 2'b01) begin failures++; $display("FAIL t3_ack_drive got=%b const=%b exp=0 const=1", dv, dc); end
        checks++; if (recieve_bytedata !== 8'h3C || n_byte - b0 !== 1) begin
            failures++; $display("FAIL t3_rx_byte got=%h n=%0d exp=3c n=1", recieve_bytedata, n_byte - b0);
        end
        m_stop();
        checks++; if (n_tmo !== t0) begin failures++; $display("FAIL t3_timeout got=%0d exp=%0d", n_tmo, t0); end
    endtask

    task automatic test_nack_rx();
        int a0;
        logic ad, ac;
        send_ackdata = 1'b0;
        m_start();
        a0 = n_ack;
        m_write(8'h55, 0, ad, ac);
        checks++; if ({ad, ac} !== 2'b11) begin failures++; $display("FAIL t4_no_ack got=%b const=%b exp=1 const=1", ad, ac); end
        checks++; if (n_ack - a0 !== 1) begin failures++; $display("FAIL t4_done_ack got=%0d exp=1", n_ack - a0); end
        checks++; if (recieve_bytedata !== 8'h55) begin failures++; $display("FAIL t4_rx_byte got=%h exp=55", recieve_bytedata); end
        checks++; if (recieve_ackdata !== 1'b0) begin failures++; $display("FAIL t4_ackrx got=%b exp=0", recieve_ackdata); end
        m_stop();
        send_ackdata = 1'b1;
    endtask

    task automatic test_restart_stop();
        int s0, b0, p0, pb0, t0;
        logic dv, dc;
        logic [3:0] part;
        t0 = n_tmo; part = 4'b1011;
        m_start();
        for (int i = 3; i >= 0; i--) m_bit(part[i], 0, dv, dc);
        s0 = n_start; b0 = n_byte;
        m_start();
        checks++; if (n_start - s0 !== 1) begin failures++; $display("FAIL t5_restart got=%0d exp=1", n_start - s0); end
        send_bytedata = 8'h4E; send_bytedatavalid = 1'b1;
        m_write(8'hA1, 0, dv, dc);
        send_bytedatavalid = 1'b0;
        checks++; if (n_byte - b0 !== 1 || recieve_bytedata !== 8'hA1) begin
            failures++; $display("FAIL t5_fresh_byte got=%h n=%0d exp=a1 n=1", recieve_bytedata, n_byte - b0);
        end
        m_bit(1'b1, 0, dv, dc);
        checks++; if (dv !== 1'b0) begin failures++; $display("FAIL t5_tx_bit7 got=%b exp=0", dv); end
        p0 = n_stop; pb0 = n_stop_bad; b0 = n_byte;
        m_stop();
        checks++; if (n_stop - p0 !== 1) begin failures++; $display("FAIL t5_stop got=%0d exp=1", n_stop - p0); end
        checks++; if (n_stop_bad !== pb0) begin failures++; $display("FAIL t5_stop_release got=%0d exp=%0d", n_stop_bad, pb0); end
        m_scl = 1'b0;
        tick(8);
        for (int i = 0; i < 2; i++) begin
            m_bit(1'b1, 0, dv, dc);
            checks++; if ({dv, dc} !== 2'b11) begin failures++; $display("FAIL t5_idle_sda got=%b const=%b exp=1 const=1", dv, dc); end
        end
        checks++; if (n_byte !== b0) begin failures++; $display("FAIL t5_idle_byte got=%0d exp=%0d", n_byte, b0); end
        m_stop();
        checks++; if (n_tmo !== t0) begin failures++; $display("FAIL t5_timeout got=%0d exp=%0d", n_tmo, t0); end
    endtask

    task automatic test_glitch_reset();
        int a0, b0, t0;
        logic dv, dc;
        t0 = n_tmo;
        send_bytedata = 8'h00; send_bytedatavalid = 1'b1;
        m_start();
        b0 = n_byte; a0 = n_ack;
        m_write(8'h5A, 2, dv, dc);
        send_bytedatavalid = 1'b0;
        checks++; if (recieve_bytedata !== 8'h5A) begin failures++; $display("FAIL t6_glitch_byte got=%h exp=5a", recieve_bytedata); end
        checks++; if (n_byte - b0 !== 1 || n_ack - a0 !== 1) begin
            failures++; $display("FAIL t6_glitch_count got=%0d/%0d exp=1/1", n_byte - b0, n_ack - a0);
        end
        m_sda = 1'b1;
        tick(8);
        m_scl = 1'b1;
        tick(8);
        checks++; if (i2c_sda_o !== 1'b0) begin failures++; $display("FAIL t6_tx_drive got=%b exp=0", i2c_sda_o); end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checks++; if ({i2c_scl_o, i2c_sda_o} !== 2'b11) begin failures++; $display("FAIL t6_reset_release got=%b exp=11", {i2c_scl_o, i2c_sda_o}); end
        checks++; if (recieve_bytedata !== 8'h00) begin failures++; $display("FAIL t6_reset_rxbyte got=%h exp=00", recieve_bytedata); end
        b0 = n_byte; a0 = n_ack;
        tick(8);
        m_scl = 1'b0;
        tick(8);
        for (int i = 0; i < 8; i++) m_bit(1'b1, 0, dv, dc);
        checks++; if (n_byte !== b0 || n_ack !== a0) begin
            failures++; $display("FAIL t6_discard got=%0d/%0d exp=0/0", n_byte - b0, n_ack - a0);
        end
        m_stop();
        checks++; if (n_tmo !== t0) begin failures++; $display("FAIL t6_timeout got=%0d exp=%0d", n_tmo, t0); end
    endtask

    initial begin
        test_reset();
        test_write_ack();
        test_tx();
        test_stretch();
        test_nack_rx();
        test_restart_stop();
        test_glitch_reset();
        tick(10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peridot_board_i2c_slave.md
Name: peridot_board_i2c_slave

Overview:
- Bit-level I2C slave PHY feeding the board serial-ROM emulation FSM.
- Synchronises and filters SCL/SDA, detects START/STOP, and deserialises received bytes / serialises transmit bytes MSB first.
- Generates or samples the 9th-clock ACK and stretches SCL at the ACK phase while the consumer is not ready.
- Byte-granular pulse/level handshake toward the FSM; pins are open-drain style.

Parameters:
FILTER_LENGTH, 3, consecutive equal synchronised samples required before filtered SCL/SDA change (1..8)
STRETCH_FEATURE, "ENABLE", "ENABLE" = honour ackwaitrequest by holding SCL low; "DISABLE" = ignore ackwaitrequest

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high reset
i2c_scl_i  in  1  SCL pin level
i2c_scl_o  out  1  SCL drive: 0 = pull low, 1 = release
i2c_sda_i  in  1  SDA pin level
i2c_sda_o  out  1  SDA drive: 0 = pull low, 1 = release
condi_start  out  1  1-clk pulse on START / repeated START
condi_stop  out  1  1-clk pulse on STOP
done_byte  out  1  1-clk pulse when 8 data bits complete (rx or tx)
ackwaitrequest  in  1  1 = stretch SCL at ACK phase
done_ack  out  1  1-clk pulse at SCL fall ending the 9th clock
send_bytedata  in  8  byte to transmit
send_bytedatavalid  in  1  1 at done_ack cycle = next byte is transmitted
recieve_bytedata  out  8  last received byte, valid from done_byte until next done_byte
send_ackdata  in  1  1 = drive ACK (SDA low) on 9th clock of a received byte
recieve_ackdata  out  1  ~SDA sampled at 9th SCL rise (1 = ACK seen)

Behaviour:
- Reset (sync): i2c_scl_o=1, i2c_sda_o=1, all pulses 0, recieve_bytedata=0, recieve_ackdata=0, state IDLE, filters preset to 1.
- Input path: 2-FF sync, then filter; scl_f/sda_f toggle only after FILTER_LENGTH equal samples. Edges detected on scl_f/sda_f vs previous cycle. condi_*/sample actions occur the cycle after the filtered edge.
- START: sda_f falls while scl_f = 1 in current and previous cycle. STOP: sda_f rises, same condition. An SDA change coinciding with an SCL edge is data, not a condition.
- States: IDLE, BIT, STRETCH, ACK.
- IDLE: outputs released; START -> BIT in rx mode, bitcnt=0.
- BIT: rx mode samples sda_f on scl_f rise into shift reg MSB first; tx mode updates i2c_sda_o one clk after scl_f fall with the next bit. After the 8th scl_f fall: done_byte pulse; rx copies shift reg to recieve_bytedata in the same cycle; go to STRETCH.
- STRETCH: if STRETCH_FEATURE="ENABLE" and ackwaitrequest=1, i2c_scl_o=0 and remain; tx mode releases SDA. When ackwaitrequest=0 (or disabled): release SCL, set SDA for ACK (rx: i2c_sda_o = ~send_ackdata; tx: 1), go to ACK.
- ACK: on scl_f rise, recieve_ackdata <= ~sda_f. On scl_f fall: done_ack pulse; if send_bytedatavalid=1 load send_bytedata, tx mode, drive bit7 one clk later; else rx mode, SDA released. bitcnt=0, go to BIT.
- START in any state: condi_start, abort byte, release SDA/SCL, rx mode, bitcnt=0, recieve_ackdata=0, to BIT.
- STOP in any state: condi_stop, release SDA/SCL, to IDLE.
- Reset mid-transfer: immediate release of both lines next clk; ongoing byte discarded.
- No address decode here; always ACKs per send_ackdata. Master NACK after tx: consumer drops send_bytedatavalid, block reverts to rx mode, SDA released.

Test Plan:
1. START, master writes 0xA0, send_ackdata=1 -> condi_start pulse; done_byte with recieve_bytedata=0xA0; i2c_sda_o=0 across 9th SCL high; recieve_ackdata=1; one done_ack pulse.
2. After ACK with send_bytedatavalid=1, send_bytedata=0x4E -> i2c_sda_o sampled on SCL highs = 0,1,0,0,1,1,1,0; master ACK -> recieve_ackdata=1; master NACK -> recieve_ackdata=0, and SDA stays released when valid=0.
3. ackwaitrequest=1 for 40 clk after 8th SCL fall -> i2c_scl_o=0 for ≥40 clk; SCL released the clk after deassert; ACK then driven.
4. send_ackdata=0 on received byte -> i2c_sda_o=1 during 9th clock; done_ack still pulses.
5. Repeated START after 4 bits -> condi_start, next 8 bits form fresh byte 0xA1; STOP during tx byte -> condi_stop and i2c_sda_o=1 by next clk.
6. SCL low glitch of FILTER_LENGTH-1 clk during bit -> no sample, no bit count advance; sync reset asserted mid-byte -> both outputs 1 next clk, no done_byte.
